// File: rtl/banked_mem_pkg.sv
// Shared constants for the four-bank word-interleaved backing memory.
package banked_mem_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int BANK_SEL_LSB = 1;
  localparam int BANK_SEL_MSB = 2;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  localparam int BANK_AW_DEF  = 13;
  localparam int BUSY_CYC_DEF = 4;
  localparam int RD_LAT_DEF   = 2;

  typedef logic [BANK_SEL_MSB-BANK_SEL_LSB:0] bank_sel_t;

  function automatic bank_sel_t bank_of(input logic [ADDR_W-1:0] addr);
    return addr[BANK_SEL_MSB:BANK_SEL_LSB];
  endfunction

endpackage

// File: rtl/banked_mem_if.sv
// Request/response bundle between the cache controller and banked_mem.
interface banked_mem_if;
  import banked_mem_pkg::*;

  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data_in;
  logic                 wr;
  logic                 rd;
  logic [DATA_W-1:0]    data_out;
  logic                 stall;
  logic [NUM_BANKS-1:0] busy;
  logic                 err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, stall, busy, err
  );

endinterface

// File: rtl/banked_mem_bank.sv
// One memory bank: storage array, occupancy down-counter, write port and
// registered read port (the read register is stage 1 of the read pipeline).
module banked_mem_bank
  import banked_mem_pkg::*;
#(
  parameter int BANK_AW  = BANK_AW_DEF,
  parameter int BUSY_CYC = BUSY_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_i,
  input  logic               wr_i,
  input  logic [BANK_AW-1:0] idx_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               busy_o,
  output logic [DATA_W-1:0]  rdata_o
);

  localparam int CW = (BUSY_CYC > 2) ? $clog2(BUSY_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BUSY_CYC - 1);

  logic [DATA_W-1:0] mem_q [2**BANK_AW];
  logic [DATA_W-1:0] rdata_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Counter holds the remaining occupied cycles after the accept edge.
  always_comb begin
    cnt_d = cnt_q;
    if (acc_i) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Contents survive reset; only the access itself is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && acc_i) begin
      if (wr_i) begin
        mem_q[idx_i] <= data_i;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_mem.sv
// Four-bank interleaved memory: bank decode, error/stall, read-data pipeline.
// Optional BANKED_MEM_ALIGN_CHK_EN flags odd byte addresses as errors.
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int BANK_AW  = BANK_AW_DEF,
  parameter int BUSY_CYC = BUSY_CYC_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  banked_mem_if.slave  bus
);

  // Stage 1 lives in the bank read register; the rest are held here.
  localparam int NS = RD_LAT - 1;

  bank_sel_t            bsel;
  logic [BANK_AW-1:0]   idx;
  logic                 req, err, stall, acc;
  logic [NUM_BANKS-1:0] busy_w;
  logic [DATA_W-1:0]    rdata_w [NUM_BANKS];

  logic                 v1_q, v1_d;
  bank_sel_t            b1_q, b1_d;
  logic [NS-1:0]        pv_q, pv_d;
  logic [DATA_W-1:0]    pd_q [NS];
  logic [DATA_W-1:0]    pd_d [NS];

  assign bsel = bank_of(bus.addr);
  assign idx  = bus.addr[BANK_SEL_MSB+BANK_AW:BANK_SEL_MSB+1];

`ifdef BANKED_MEM_ALIGN_CHK_EN
  always_comb begin
    req = bus.rd | bus.wr;
    err = (bus.rd & bus.wr) | (req & bus.addr[0]);
  end
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = bus.addr[0];

  always_comb begin
    req = bus.rd | bus.wr;
    err = bus.rd & bus.wr;
  end
`endif

  always_comb begin
    stall = req & ~err & busy_w[bsel];
    acc   = req & ~err & ~busy_w[bsel] & ~rst;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    banked_mem_bank #(
      .BANK_AW  (BANK_AW),
      .BUSY_CYC (BUSY_CYC)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .acc_i   (acc && (bsel == bank_sel_t'(b))),
      .wr_i    (bus.wr),
      .idx_i   (idx),
      .data_i  (bus.data_in),
      .busy_o  (busy_w[b]),
      .rdata_o (rdata_w[b])
    );
  end

  always_comb begin
    v1_d    = acc & bus.rd;
    b1_d    = bsel;
    pv_d[0] = v1_q;
    pd_d[0] = rdata_w[b1_q];
    for (int i = 1; i < NS; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      b1_q <= '0;
      pv_q <= '0;
    end else begin
      v1_q <= v1_d;
      b1_q <= b1_d;
      pv_q <= pv_d;
    end
  end

  // Data stages need no reset: the valid bits gate them onto data_out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      pd_q[i] <= pd_d[i];
    end
  end

  assign bus.data_out = pv_q[NS-1] ? pd_q[NS-1] : '0;
  assign bus.stall    = stall;
  assign bus.err      = err;
  assign bus.busy     = busy_w;

endmodule

// File: tb/tb_banked_mem.sv
// Directed bench for banked_mem; inputs change on the falling edge and
// outputs are checked 1 time unit later, before the next rising edge.
module tb_banked_mem;

  logic clk;
  logic rst;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;

  banked_mem_if bus ();

  banked_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_busy, input logic [15:0] e_dout,
                         input logic e_stall, input logic e_err);
    chk({tag, ".busy"},  {12'h0, bus.busy}, {12'h0, e_busy});
    chk({tag, ".dout"},  bus.data_out, e_dout);
    chk({tag, ".stall"}, {15'h0, bus.stall}, {15'h0, e_stall});
    chk({tag, ".err"},   {15'h0, bus.err}, {15'h0, e_err});
  endtask

  task automatic cyc(input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic rs);
    @(negedge clk);
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    rst         = rs;
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 16'h0; bus.data_in = 16'h0;
    cyc(0, 0, 16'h0, 16'h0, 1);
    cyc(0, 0, 16'h0, 16'h0, 1);

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 16'h0, 16'h0, 0);
      chk_all("idle", 4'b0000, 16'h0000, 0, 0);
    end

    // write then read same word, re-accept exactly BUSY_CYC later
    cyc(0, 1, 16'h0008, 16'hBEEF, 0); chk_all("wr_T", 4'b0000, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 16'h0, 16'h0, 0);     chk_all("wr_busy", 4'b0001, 16'h0, 0, 0);
    end
    cyc(1, 0, 16'h0008, 16'h0, 0);    chk_all("rd_T4", 4'b0000, 16'h0, 0, 0);
    idle_n(1);                        chk_all("rd_T5", 4'b0001, 16'h0, 0, 0);
    idle_n(1);                        chk_all("rd_T6", 4'b0001, 16'hBEEF, 0, 0);
    idle_n(1);                        chk_all("rd_T7", 4'b0001, 16'h0, 0, 0);
    idle_n(1);

    // preload one word per bank, then read all four back to back
    cyc(0, 1, 16'h0040, 16'h1111, 0);
    cyc(0, 1, 16'h0042, 16'h2222, 0);
    cyc(0, 1, 16'h0044, 16'h3333, 0);
    cyc(0, 1, 16'h0046, 16'h4444, 0);
    idle_n(3);
    cyc(1, 0, 16'h0040, 16'h0, 0);    chk_all("burst0", 4'b0000, 16'h0, 0, 0);
    cyc(1, 0, 16'h0042, 16'h0, 0);    chk_all("burst1", 4'b0001, 16'h0, 0, 0);
    cyc(1, 0, 16'h0044, 16'h0, 0);    chk_all("burst2", 4'b0011, 16'h1111, 0, 0);
    cyc(1, 0, 16'h0046, 16'h0, 0);    chk_all("burst3", 4'b0111, 16'h2222, 0, 0);
    idle_n(1);                        chk_all("burst4", 4'b1110, 16'h3333, 0, 0);
    idle_n(1);                        chk_all("burst5", 4'b1100, 16'h4444, 0, 0);
    idle_n(1);                        chk_all("burst6", 4'b1000, 16'h0, 0, 0);
    idle_n(1);                        chk_all("burst7", 4'b0000, 16'h0, 0, 0);

    // same-bank conflict: second read stalls until the bank frees
    cyc(0, 1, 16'h0010, 16'hAAAA, 0);
    idle_n(3);
    cyc(0, 1, 16'h0018, 16'h5555, 0);
    idle_n(3);
    cyc(1, 0, 16'h0010, 16'h0, 0);    chk_all("conf_T", 4'b0000, 16'h0, 0, 0);
    cyc(1, 0, 16'h0018, 16'h0, 0);    chk_all("conf_T1", 4'b0001, 16'h0, 1, 0);
    cyc(1, 0, 16'h0018, 16'h0, 0);    chk_all("conf_T2", 4'b0001, 16'hAAAA, 1, 0);
    cyc(1, 0, 16'h0018, 16'h0, 0);    chk_all("conf_T3", 4'b0001, 16'h0, 1, 0);
    cyc(1, 0, 16'h0018, 16'h0, 0);    chk_all("conf_T4", 4'b0000, 16'h0, 0, 0);
    idle_n(1);                        chk_all("conf_T5", 4'b0001, 16'h0, 0, 0);
    idle_n(1);                        chk_all("conf_T6", 4'b0001, 16'h5555, 0, 0);
    idle_n(1);                        chk_all("conf_T7", 4'b0001, 16'h0, 0, 0);
    idle_n(1);

    // rd & wr together is an error and must not touch memory
    cyc(0, 1, 16'h0002, 16'h1234, 0);
    idle_n(3);
    cyc(1, 1, 16'h0002, 16'hDEAD, 0); chk_all("err_T", 4'b0000, 16'h0, 0, 1);
    idle_n(1);                        chk_all("err_T1", 4'b0000, 16'h0, 0, 0);
    idle_n(1);                        chk_all("err_T2", 4'b0000, 16'h0, 0, 0);
    cyc(1, 0, 16'h0002, 16'h0, 0);    chk_all("err_rd", 4'b0000, 16'h0, 0, 0);
    idle_n(2);                        chk_all("err_rd2", 4'b0010, 16'h1234, 0, 0);
    idle_n(3);

    // reset mid-flight: read discarded, busy cleared, write on reset edge dropped
    cyc(1, 0, 16'h0040, 16'h0, 0);    chk_all("rst_T", 4'b0000, 16'h0, 0, 0);
    cyc(0, 1, 16'h0042, 16'hFFFF, 1); chk_all("rst_T1", 4'b0001, 16'h0, 0, 0);
    cyc(1, 0, 16'h0040, 16'h0, 0);    chk_all("rst_T2", 4'b0000, 16'h0, 0, 0);
    cyc(1, 0, 16'h0042, 16'h0, 0);    chk_all("rst_T3", 4'b0001, 16'h0, 0, 0);
    idle_n(1);                        chk_all("rst_T4", 4'b0011, 16'h1111, 0, 0);
    idle_n(1);                        chk_all("rst_T5", 4'b0011, 16'h2222, 0, 0);
    idle_n(3);

    // odd byte address
    cyc(1, 0, 16'h0003, 16'h0, 0);
`ifdef BANKED_MEM_ALIGN_CHK_EN
    chk_all("algn_T", 4'b0000, 16'h0, 0, 1);
    idle_n(1);                        chk_all("algn_T1", 4'b0000, 16'h0, 0, 0);
    idle_n(1);                        chk_all("algn_T2", 4'b0000, 16'h0, 0, 0);
`else
    chk_all("algn_T", 4'b0000, 16'h0, 0, 0);
    idle_n(1);                        chk_all("algn_T1", 4'b0010, 16'h0, 0, 0);
    idle_n(1);                        chk_all("algn_T2", 4'b0010, 16'h1234, 0, 0);
`endif
    idle_n(1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
